pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_tick_gen.sv | 29 ++
 rtl/pong_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the pong controller
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        MOVE  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] LD_OFF = 4'b0000;
    localparam logic [3:0] LD_ALL = 4'b1111;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    // Ball position to LED pattern; pos 3 lights LD[3]
    function automatic logic [3:0] pos_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// rtl/pong_tick_gen.sv - prescaler producing a one-cycle ball-step tick
module pong_tick_gen #(
    parameter int TICK_DIV = 25000000,
    parameter int TICK_W   = 25
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    // Free-running 0..TICK_DIV-1 counter; clr restarts the period
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - two-player 4-LED pong sequencer
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int TICK_W    = 25,
    parameter int WIN_SCORE = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       BtnL,
    input  logic       BtnR,
    output logic [3:0] LD,
    output logic [3:0] ScoreL,
    output logic [3:0] ScoreR,
    output logic       GameOver,
    output logic       Winner
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state, state_n;
    logic [1:0] pos, pos_n;
    logic       dir, dir_n;
    logic       hit_l, hit_l_n;
    logic       hit_r, hit_r_n;
    logic       scorer, scorer_n;
    logic [3:0] ld_n, score_l_n, score_r_n;
    logic       game_over_n, winner_n;

    logic       tick;
    logic       start_ok;
    logic       btn_l_ok, btn_r_ok;
    logic       at_end, hit_now, scorer_won;
    logic [1:0] pos_fwd, pos_back;

    // Start only matters when no rally is in progress
    assign start_ok = Start && ((state == IDLE) || (state == OVER));

    pong_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (start_ok),
        .tick (tick)
    );

    // A press counts only while the ball sits at that player's end heading toward them
    assign btn_r_ok = BtnR && (state == MOVE) && (pos == 2'd0) && (dir == DIR_R);
    assign btn_l_ok = BtnL && (state == MOVE) && (pos == 2'd3) && (dir == DIR_L);

    assign at_end     = (dir == DIR_R) ? (pos == 2'd0) : (pos == 2'd3);
    assign hit_now    = (dir == DIR_R) ? (hit_r || btn_r_ok) : (hit_l || btn_l_ok);
    assign pos_fwd    = (dir == DIR_R) ? pos - 2'd1 : pos + 2'd1;
    assign pos_back   = (dir == DIR_R) ? pos + 2'd1 : pos - 2'd1;
    assign scorer_won = scorer ? (ScoreR == WIN) : (ScoreL == WIN);

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decision
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_ok) state_n = SERVE;
            SERVE: if (tick) state_n = MOVE;
            MOVE:  if (tick && at_end && !hit_now) state_n = POINT;
            POINT: if (tick) state_n = scorer_won ? OVER : SERVE;
            OVER:  if (start_ok) state_n = SERVE;
            default: state_n = IDLE;
        endcase
    end

    // Next values for the ball, scores and registered outputs
    always_comb begin
        pos_n       = pos;
        dir_n       = dir;
        scorer_n    = scorer;
        score_l_n   = ScoreL;
        score_r_n   = ScoreR;
        game_over_n = GameOver;
        winner_n    = Winner;
        ld_n        = LD;
        hit_l_n     = tick ? 1'b0 : (hit_l || btn_l_ok);
        hit_r_n     = tick ? 1'b0 : (hit_r || btn_r_ok);

        case (state)
            IDLE, OVER: begin
                if (start_ok) begin
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    pos_n       = 2'd3;
                    dir_n       = DIR_R;
                    game_over_n = 1'b0;
                    winner_n    = 1'b0;
                    ld_n        = pos_onehot(2'd3);
                end else if (state == IDLE) begin
                    ld_n = LD_OFF;
                end else if (tick) begin
                    ld_n = ~LD;
                end
            end
            SERVE: begin
                ld_n = pos_onehot(pos);
            end
            MOVE: begin
                if (tick) begin
                    if (!at_end) begin
                        pos_n = pos_fwd;
                        ld_n  = pos_onehot(pos_fwd);
                    end else if (hit_now) begin
                        dir_n = ~dir;
                        pos_n = pos_back;
                        ld_n  = pos_onehot(pos_back);
                    end else begin
                        // Ball got past the player at this end: the other side scores
                        if (dir == DIR_R) begin
                            scorer_n = 1'b0;
                            if (ScoreL < WIN) score_l_n = ScoreL + 4'd1;
                        end else begin
                            scorer_n = 1'b1;
                            if (ScoreR < WIN) score_r_n = ScoreR + 4'd1;
                        end
                        ld_n = LD_ALL;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (scorer_won) begin
                        game_over_n = 1'b1;
                        winner_n    = scorer;
                        ld_n        = LD_ALL;
                    end else if (scorer == 1'b0) begin
                        // Right player missed, so the serve starts from the right end
                        pos_n = 2'd0;
                        dir_n = DIR_L;
                        ld_n  = pos_onehot(2'd0);
                    end else begin
                        pos_n = 2'd3;
                        dir_n = DIR_R;
                        ld_n  = pos_onehot(2'd3);
                    end
                end
            end
            default: begin
                ld_n = LD_OFF;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pos      <= 2'd3;
            dir      <= DIR_R;
            hit_l    <= 1'b0;
            hit_r    <= 1'b0;
            scorer   <= 1'b0;
            ScoreL   <= 4'd0;
            ScoreR   <= 4'd0;
            GameOver <= 1'b0;
            Winner   <= 1'b0;
            LD       <= LD_OFF;
        end else begin
            pos      <= pos_n;
            dir      <= dir_n;
            hit_l    <= hit_l_n;
            hit_r    <= hit_r_n;
            scorer   <= scorer_n;
            ScoreL   <= score_l_n;
            ScoreR   <= score_r_n;
            GameOver <= game_over_n;
            Winner   <= winner_n;
            LD       <= ld_n;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed vector bench for pong_game_ctrl
module tb_pong_game_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       btnl;
    logic       btnr;
    logic [3:0] ld;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cycles;
        logic       start;
        logic       btnl;
        logic       btnr;
        logic [3:0] ld;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic       win;
    } vec_t;

    vec_t vecs[$];

    pong_game_ctrl #(
        .TICK_DIV  (4),
        .TICK_W    (3),
        .WIN_SCORE (2)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .BtnL     (btnl),
        .BtnR     (btnr),
        .LD       (ld),
        .ScoreL   (score_l),
        .ScoreR   (score_r),
        .GameOver (game_over),
        .Winner   (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input int c, input logic s, input logic bl, input logic br,
                       input logic [3:0] l, input logic [3:0] sl, input logic [3:0] sr,
                       input logic go, input logic w);
        vec_t v;
        v.cycles = c; v.start = s; v.btnl = bl; v.btnr = br;
        v.ld = l; v.sl = sl; v.sr = sr; v.go = go; v.win = w;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btnl = 1'b0; btnr = 1'b0;

        // Each entry: pulse inputs for one cycle, run 'cycles' cycles, then check
        add(1, 1, 0, 0, 4'b1000, 0, 0, 0, 0);  // Start -> SERVE
        add(4, 0, 0, 0, 4'b1000, 0, 0, 0, 0);  // MOVE at pos 3
        add(4, 0, 0, 0, 4'b0100, 0, 0, 0, 0);
        add(4, 0, 0, 0, 4'b0010, 0, 0, 0, 0);
        add(4, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
        add(4, 0, 0, 1, 4'b0010, 0, 0, 0, 0);  // right return
        add(4, 0, 0, 0, 4'b0100, 0, 0, 0, 0);
        add(4, 0, 1, 0, 4'b1000, 0, 0, 0, 0);  // BtnL outside window ignored
        add(4, 0, 1, 0, 4'b0100, 0, 0, 0, 0);  // left return
        add(4, 0, 0, 0, 4'b0010, 0, 0, 0, 0);
        add(4, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
        add(4, 0, 0, 0, 4'b1111, 1, 0, 0, 0);  // right miss -> POINT
        add(4, 0, 0, 0, 4'b0001, 1, 0, 0, 0);  // SERVE from right end
        add(4, 0, 0, 0, 4'b0001, 1, 0, 0, 0);  // MOVE, pos unchanged
        add(4, 0, 0, 0, 4'b0010, 1, 0, 0, 0);
        add(4, 0, 0, 0, 4'b0100, 1, 0, 0, 0);
        add(4, 0, 0, 0, 4'b1000, 1, 0, 0, 0);
        add(4, 0, 1, 0, 4'b0100, 1, 0, 0, 0);  // left return
        add(4, 0, 0, 0, 4'b0010, 1, 0, 0, 0);
        add(4, 0, 0, 0, 4'b0001, 1, 0, 0, 0);
        add(4, 0, 0, 0, 4'b1111, 2, 0, 0, 0);  // second right miss
        add(4, 0, 0, 0, 4'b1111, 2, 0, 1, 0);  // OVER, left wins
        add(4, 0, 0, 0, 4'b0000, 2, 0, 1, 0);  // blink
        add(4, 0, 0, 0, 4'b1111, 2, 0, 1, 0);
        add(1, 1, 0, 0, 4'b1000, 0, 0, 0, 0);  // restart from OVER

        cyc(3);
        chk("reset_ld", 0, ld, 4'b0000);
        chk("reset_sl", 0, score_l, 4'd0);
        chk("reset_sr", 0, score_r, 4'd0);
        chk("reset_go", 0, {3'b000, game_over}, 4'd0);
        chk("reset_win", 0, {3'b000, winner}, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            btnl  = vecs[i].btnl;
            btnr  = vecs[i].btnr;
            cyc(1);
            start = 1'b0; btnl = 1'b0; btnr = 1'b0;
            cyc(vecs[i].cycles - 1);
            chk("vec_ld", i, ld, vecs[i].ld);
            chk("vec_sl", i, score_l, vecs[i].sl);
            chk("vec_sr", i, score_r, vecs[i].sr);
            chk("vec_go", i, {3'b000, game_over}, {3'b000, vecs[i].go});
            chk("vec_win", i, {3'b000, winner}, {3'b000, vecs[i].win});
        end

        // Button arriving exactly on the tick that closes the pos-0 window
        cyc(4); chk("seq_a_ld", 0, ld, 4'b1000);
        cyc(4); chk("seq_a_ld", 1, ld, 4'b0100);
        cyc(4); chk("seq_a_ld", 2, ld, 4'b0010);
        cyc(4); chk("seq_a_ld", 3, ld, 4'b0001);
        cyc(3);
        btnr = 1'b1; cyc(1); btnr = 1'b0;
        chk("edge_hit_ld", 0, ld, 4'b0010);
        cyc(4); chk("seq_a_ld", 4, ld, 4'b0100);
        cyc(4); chk("seq_a_ld", 5, ld, 4'b1000);
        btnl = 1'b1; cyc(1); btnl = 1'b0;
        cyc(3); chk("seq_a_ld", 6, ld, 4'b0100);
        cyc(4); chk("seq_a_ld", 7, ld, 4'b0010);

        // BtnR held from pos 1 through pos 0
        btnr = 1'b1;
        cyc(4); chk("held_ld", 0, ld, 4'b0001);
        cyc(2); btnr = 1'b0;
        cyc(2); chk("held_hit_ld", 0, ld, 4'b0010);

        // Left miss gives ScoreR = 1 and a serve from the left end
        cyc(4); chk("seq_b_ld", 0, ld, 4'b0100);
        cyc(4); chk("seq_b_ld", 1, ld, 4'b1000);
        cyc(4); chk("seq_b_ld", 2, ld, 4'b1111);
        chk("seq_b_sr", 0, score_r, 4'd1);
        cyc(4); chk("seq_b_ld", 3, ld, 4'b1000);
        cyc(4); chk("seq_b_ld", 4, ld, 4'b1000);
        cyc(4); chk("seq_b_ld", 5, ld, 4'b0100);

        // Start during MOVE is ignored
        start = 1'b1; cyc(1); start = 1'b0;
        chk("mid_start_ld", 0, ld, 4'b0100);
        chk("mid_start_sl", 0, score_l, 4'd0);
        chk("mid_start_sr", 0, score_r, 4'd1);
        chk("mid_start_go", 0, {3'b000, game_over}, 4'd0);
        cyc(3); chk("mid_start_ld", 1, ld, 4'b0010);

        // Reset mid-flight aborts without awarding a point
        rst = 1'b1; cyc(1);
        chk("mid_rst_ld", 0, ld, 4'b0000);
        chk("mid_rst_sl", 0, score_l, 4'd0);
        chk("mid_rst_sr", 0, score_r, 4'd0);
        chk("mid_rst_go", 0, {3'b000, game_over}, 4'd0);
        rst = 1'b0;
        cyc(8);
        chk("idle_ld", 0, ld, 4'b0000);
        chk("idle_sr", 0, score_r, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
